// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back merge buffer.
package wb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned WB_DATA_W     = 32;

  typedef logic [4:0] dest_t;

  localparam dest_t REG_ZERO = 5'd0;

  typedef struct packed {
    dest_t                dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for the long-latency unit: storage, wrapping pointers and occupancy count.
// Optional WB_PENDING_MASK_EN adds a per-register pending mask over the valid entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  dest_t             push_dest_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output dest_t             head_dest_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]       pending_mask_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dest_t             dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  assign empty_o     = (count_q == {CNT_W{1'b0}});
  assign full_o      = (count_q == FULL_CNT);
  assign head_dest_o = dest_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Pointer and count update; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since validity comes from the count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      dest_q[wr_ptr_q] <= push_dest_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

`ifdef WB_PENDING_MASK_EN
  // Walk slots from the head; only the first count_q slots hold live entries.
  always_comb begin
    pending_mask_o = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pending_mask_o[dest_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end else begin
        pending_mask_o = pending_mask_o;
      end
    end
  end
`endif

endmodule

// File: rtl/wb_merge_buffer.sv
// Merges two pipe lanes and a queued long-latency result stream onto two register-file write ports.
// Optional WB_PENDING_MASK_EN exposes pending_mask of destinations still queued.
module wb_merge_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l0_valid,
  input  logic [4:0]        l0_dest,
  input  logic [DATA_W-1:0] l0_data,
  input  logic              l1_valid,
  input  logic [4:0]        l1_dest,
  input  logic [DATA_W-1:0] l1_data,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_dest,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              we1,
  output logic [4:0]        writeRegister1,
  output logic [DATA_W-1:0] writeData1,
  output logic              we2,
  output logic [4:0]        writeRegister2,
  output logic [DATA_W-1:0] writeData2
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]       pending_mask
`endif
);

  dest_t             head_dest_s;
  logic [DATA_W-1:0] head_data_s;
  logic              empty_s, full_s;
  logic              l0_act_s, l1_act_s, kill_s, issue1_s, issue2_s, push_s, pop_s;

  logic              we1_q, we1_d, we2_q, we2_d;
  dest_t             wr1_q, wr1_d, wr2_q, wr2_d;
  logic [DATA_W-1:0] wd1_q, wd1_d, wd2_q, wd2_d;

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_dest_i (mdu_dest),
    .push_data_i (mdu_data),
    .pop_i       (pop_s),
    .head_dest_o (head_dest_s),
    .head_data_o (head_data_s),
    .empty_o     (empty_s),
    .full_o      (full_s)
`ifdef WB_PENDING_MASK_EN
    ,
    .pending_mask_o (pending_mask)
`endif
  );

  assign mdu_ready = ~full_s;

  // Arbitration: lanes are younger, so a matching lane dest retires the head unwritten.
  always_comb begin
    l0_act_s = l0_valid && (l0_dest != REG_ZERO);
    l1_act_s = l1_valid && (l1_dest != REG_ZERO);
    kill_s   = !empty_s && ((l0_valid && (l0_dest == head_dest_s)) ||
                            (l1_valid && (l1_dest == head_dest_s)));
    issue1_s = !empty_s && !kill_s && !l0_act_s;
    issue2_s = !empty_s && !kill_s && l0_act_s && !l1_act_s;
    pop_s    = !rst && (kill_s || issue1_s || issue2_s);
    push_s   = !rst && mdu_valid && !full_s && (mdu_dest != REG_ZERO);

    we1_d = l0_act_s || issue1_s;
    if (l0_act_s) begin
      wr1_d = l0_dest;
      wd1_d = l0_data;
    end else if (issue1_s) begin
      wr1_d = head_dest_s;
      wd1_d = head_data_s;
    end else begin
      wr1_d = REG_ZERO;
      wd1_d = {DATA_W{1'b0}};
    end

    we2_d = l1_act_s || issue2_s;
    if (l1_act_s) begin
      wr2_d = l1_dest;
      wd2_d = l1_data;
    end else if (issue2_s) begin
      wr2_d = head_dest_s;
      wd2_d = head_data_s;
    end else begin
      wr2_d = REG_ZERO;
      wd2_d = {DATA_W{1'b0}};
    end
  end

  // Registered write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      we1_q <= 1'b0;
      wr1_q <= REG_ZERO;
      wd1_q <= {DATA_W{1'b0}};
      we2_q <= 1'b0;
      wr2_q <= REG_ZERO;
      wd2_q <= {DATA_W{1'b0}};
    end else begin
      we1_q <= we1_d;
      wr1_q <= wr1_d;
      wd1_q <= wd1_d;
      we2_q <= we2_d;
      wr2_q <= wr2_d;
      wd2_q <= wd2_d;
    end
  end

  assign we1            = we1_q;
  assign writeRegister1 = wr1_q;
  assign writeData1     = wd1_q;
  assign we2            = we2_q;
  assign writeRegister2 = wr2_q;
  assign writeData2     = wd2_q;

endmodule

// File: tb/tb_wb_merge_buffer.sv
// Directed bench for wb_merge_buffer: hand-computed expectations checked #1 after each posedge.
module tb_wb_merge_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        l0_valid, l1_valid, mdu_valid;
  logic [4:0]  l0_dest, l1_dest, mdu_dest;
  logic [31:0] l0_data, l1_data, mdu_data;
  logic        mdu_ready, we1, we2;
  logic [4:0]  writeRegister1, writeRegister2;
  logic [31:0] writeData1, writeData2;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] pending_mask;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_merge_buffer #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .l0_valid(l0_valid), .l0_dest(l0_dest), .l0_data(l0_data),
    .l1_valid(l1_valid), .l1_dest(l1_dest), .l1_data(l1_data),
    .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .we1(we1), .writeRegister1(writeRegister1), .writeData1(writeData1),
    .we2(we2), .writeRegister2(writeRegister2), .writeData2(writeData2)
`ifdef WB_PENDING_MASK_EN
    , .pending_mask(pending_mask)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [4:0] d1, input logic [31:0] x1);
    l0_valid = v0; l0_dest = d0; l0_data = x0;
    l1_valid = v1; l1_dest = d1; l1_data = x1;
  endtask

  task automatic mdu(input logic v, input logic [4:0] d, input logic [31:0] x);
    mdu_valid = v; mdu_dest = d; mdu_data = x;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_p1(input string tag, input logic e, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we1"}, 64'(we1), 64'(e));
    chk({tag, ".wr1"}, 64'(writeRegister1), 64'(r));
    chk({tag, ".wd1"}, 64'(writeData1), 64'(d));
  endtask

  task automatic chk_p2(input string tag, input logic e, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we2"}, 64'(we2), 64'(e));
    chk({tag, ".wr2"}, 64'(writeRegister2), 64'(r));
    chk({tag, ".wd2"}, 64'(writeData2), 64'(d));
  endtask

  initial begin
    rst = 1'b1;
    lanes(1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd10, 32'hBEEF);
    mdu(1'b1, 5'd11, 32'h1234);
    tick; tick;
    chk_p1("reset", 1'b0, 5'd0, 32'd0);
    chk_p2("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.ready", 64'(mdu_ready), 64'd1);
    rst = 1'b0;
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("idle_after_reset", 1'b0, 5'd0, 32'd0);

    // Both lanes in one cycle
    lanes(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    tick;
    chk_p1("dual", 1'b1, 5'd3, 32'h11);
    chk_p2("dual", 1'b1, 5'd4, 32'h22);

    // mdu result waits behind busy lanes, then issues on port 1
    lanes(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    mdu(1'b1, 5'd7, 32'hABCD);
    tick;
    chk_p1("wait0", 1'b1, 5'd1, 32'hA1);
    mdu(1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("wait1", 1'b1, 5'd1, 32'hA1);
    tick;
    chk_p1("wait2", 1'b1, 5'd1, 32'hA1);
`ifdef WB_PENDING_MASK_EN
    chk("mask7", 64'(pending_mask), 64'h80);
`endif
    lanes(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hA2);
    tick;
    chk_p1("mdu_issue", 1'b1, 5'd7, 32'hABCD);
    chk_p2("mdu_issue", 1'b1, 5'd2, 32'hA2);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("no_stale7", 1'b0, 5'd0, 32'd0);

    // Fill FIFO with lanes saturated
    lanes(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      mdu(1'b1, 5'(8 + i), 32'(32'h100 + i));
      tick;
      chk("fill.ready", 64'(mdu_ready), (i == 3) ? 64'd0 : 64'd1);
    end
    mdu(1'b1, 5'd12, 32'h104);
    tick;
    chk("held.ready", 64'(mdu_ready), 64'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hB2);
    tick;
    chk_p1("drain_one", 1'b1, 5'd8, 32'h100);
    chk("after_drain.ready", 64'(mdu_ready), 64'd1);
    lanes(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2);
    tick;
    chk("refill.ready", 64'(mdu_ready), 64'd0);
    mdu(1'b0, 5'd0, 32'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_p1("drain_seq", 1'b1, 5'(9 + i), 32'(32'h101 + i));
      chk("drain_seq.we2", 64'(we2), 64'd0);
    end
    tick;
    chk_p1("drained_idle", 1'b0, 5'd0, 32'd0);
    chk("drained.ready", 64'(mdu_ready), 64'd1);

    // Head issues on port 2 when only lane 0 is busy
    lanes(1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2);
    mdu(1'b1, 5'd13, 32'h5);
    tick;
    mdu(1'b0, 5'd0, 32'd0);
    lanes(1'b1, 5'd1, 32'hC1, 1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("p2_issue", 1'b1, 5'd1, 32'hC1);
    chk_p2("p2_issue", 1'b1, 5'd13, 32'h5);

    // Younger lane write to the same dest retires the head unwritten
    lanes(1'b1, 5'd1, 32'hD1, 1'b1, 5'd2, 32'hD2);
    mdu(1'b1, 5'd5, 32'h55);
    tick;
    mdu(1'b0, 5'd0, 32'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h77);
    tick;
    chk_p1("kill", 1'b0, 5'd0, 32'd0);
    chk_p2("kill", 1'b1, 5'd5, 32'h77);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("no_stale5", 1'b0, 5'd0, 32'd0);
    chk_p2("no_stale5", 1'b0, 5'd0, 32'd0);

    // Dest 0 is discarded on both lane and mdu paths
    lanes(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    mdu(1'b1, 5'd0, 32'h98);
    tick;
    chk_p1("zero", 1'b0, 5'd0, 32'd0);
    chk("zero.ready", 64'(mdu_ready), 64'd1);
    mdu(1'b0, 5'd0, 32'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick;
    chk_p1("zero_not_queued", 1'b0, 5'd0, 32'd0);

    // Reset with three queued entries
    lanes(1'b1, 5'd1, 32'hE1, 1'b1, 5'd2, 32'hE2);
    for (int i = 0; i < 3; i++) begin
      mdu(1'b1, 5'(20 + i), 32'(32'h200 + i));
      tick;
    end
    mdu(1'b0, 5'd0, 32'd0);
`ifdef WB_PENDING_MASK_EN
    chk("mask3", 64'(pending_mask), 64'h0070_0000);
`endif
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_p1("mid_rst", 1'b0, 5'd0, 32'd0);
    chk_p2("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_rst.ready", 64'(mdu_ready), 64'd1);
`ifdef WB_PENDING_MASK_EN
    chk("mid_rst.mask", 64'(pending_mask), 64'd0);
`endif
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_p1("post_rst", 1'b0, 5'd0, 32'd0);
      chk_p2("post_rst", 1'b0, 5'd0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
